// File: rtl/ifb_pkg.sv
// Shared types and default geometry for the instruction fetch buffer.
package ifb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Default geometry: 4 lines of 4 words each.
  localparam int DEF_LINES = 4;
  localparam int DEF_WORDS = 4;

  // Address field widths for the default geometry.
  // The two low byte-offset bits are never part of the tag.
  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

endpackage

// File: rtl/ifb_line_ram.sv
// Data storage for the fetch buffer.
// One synchronous write port and one combinational read port.
module ifb_line_ram
  import ifb_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(LINES)-1:0] wr_idx_i,
  input  logic [$clog2(WORDS)-1:0] wr_off_i,
  input  logic [31:0]              wr_data_i,
  input  logic [$clog2(LINES)-1:0] rd_idx_i,
  input  logic [$clog2(WORDS)-1:0] rd_off_i,
  output logic [31:0]              rd_data_o
);

  logic [31:0] mem_q [LINES][WORDS];

  // Refill words land here one at a time.
  // Contents need no reset because the valid bits in the top gate every use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/inst_fetch_buf.sv
// Direct-mapped instruction line buffer.
// It behaves as a one-cycle synchronous SRAM on hits.
// On a miss it stalls the fetch stage and refills the whole line
// from backing memory, in word order.
module inst_fetch_buf
  import ifb_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int offW = $clog2(WORDS);
  localparam int idxW = $clog2(LINES);
  localparam int tagW = 30 - offW - idxW;

  state_e            state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic [offW-1:0]   cnt_q, cnt_d;
  logic              invPend_q, invPend_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [tagW-1:0]   tag_q [LINES];

  logic [idxW-1:0]   reqIdx, fillIdx, rdIdx;
  logic [offW-1:0]   reqOff, fillOff, rdOff;
  logic [tagW-1:0]   reqTag, fillTag;
  logic [31:0]       rdData;
  logic              hit, ramWe, lastAck;

  assign reqOff  = inst_sram_addr[offW+1:2];
  assign reqIdx  = inst_sram_addr[idxW+offW+1:offW+2];
  assign reqTag  = inst_sram_addr[31:idxW+offW+2];
  assign fillOff = addr_q[offW+1:2];
  assign fillIdx = addr_q[idxW+offW+1:offW+2];
  assign fillTag = addr_q[31:idxW+offW+2];

  // A same-cycle invalidate forces a lookup to miss.
  assign hit     = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag) && !inv;
  assign ramWe   = (state_q == REFILL) && mem_ack;
  assign lastAck = ramWe && (cnt_q == offW'(WORDS - 1));

  // During a refill the read port points at the word originally requested.
  // This lets the final ack return it without a second lookup.
  assign rdIdx = (state_q == REFILL) ? fillIdx : reqIdx;
  assign rdOff = (state_q == REFILL) ? fillOff : reqOff;

  ifb_line_ram #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_line_ram (
    .clk       (clk),
    .we_i      (ramWe),
    .wr_idx_i  (fillIdx),
    .wr_off_i  (cnt_q),
    .wr_data_i (mem_rdata),
    .rd_idx_i  (rdIdx),
    .rd_off_i  (rdOff),
    .rd_data_o (rdData)
  );

  // Next-state logic: lookups in IDLE, word-by-word fill in REFILL.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    invPend_d = invPend_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (inv) begin
          valid_d = '0;
        end
        if (inst_sram_en) begin
          if (inst_sram_addr[1:0] != 2'b00) begin
            rdata_d = '0;
          end else if (hit) begin
            rdata_d = rdData;
          end else begin
            addr_d  = inst_sram_addr[31:2];
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        if (inv) begin
          valid_d   = '0;
          invPend_d = 1'b1;
        end
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (lastAck) begin
            valid_d[fillIdx] = !(invPend_q || inv);
            invPend_d        = 1'b0;
            // The last word is being written this edge, so the RAM does not hold it yet.
            rdata_d = (fillOff == offW'(WORDS - 1)) ? mem_rdata : rdData;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers.
  // Reset abandons any refill that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      invPend_q <= 1'b0;
      rdata_q   <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      invPend_q <= invPend_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
    end
  end

  // The tag is written once, when the line completes.
  // It is meaningful only while the line's valid bit is set.
  always_ff @(posedge clk) begin
    if (lastAck) begin
      tag_q[fillIdx] <= fillTag;
    end
  end

  assign inst_sram_rdata = rdata_q;
  assign inst_stall      = (state_q == REFILL);
  assign mem_req         = (state_q == REFILL);
  assign mem_addr        = (state_q == REFILL) ? {addr_q[31:offW+2], cnt_q, 2'b00} : 32'h0;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed self-checking bench for inst_fetch_buf.
// The backing memory returns data equal to the word address.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  inst_fetch_buf dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_stall      (inst_stall),
    .inv             (inv),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic [31:0] addr,
                               input logic iv, input logic ack, input logic [31:0] rd);
    rst            = r;
    inst_sram_en   = en;
    inst_sram_addr = addr;
    inv            = iv;
    mem_ack        = ack;
    mem_rdata      = rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  // Acks one word per cycle for a full 4-word line starting at base.
  // Optionally pulses inv during the word numbered invAt.
  task automatic doRefill(input logic [31:0] base, input logic [31:0] addr, input int invAt);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, addr, (k == invAt), 1'b1, base + 32'(4 * k));
      checkOutput("refill_addr", mem_addr, base + 32'(4 * k));
      checkOutput("refill_stall", {31'b0, inst_stall}, 32'd1);
      checkOutput("refill_req", {31'b0, mem_req}, 32'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, 32'h0);
    checkOutput("refill_done_stall", {31'b0, inst_stall}, 32'd0);
  endtask

  initial begin
    // Reset held for two cycles.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_rdata", inst_sram_rdata, 32'h0);
    checkOutput("rst_stall", {31'b0, inst_stall}, 32'd0);
    checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_maddr", mem_addr, 32'h0);

    // Cold miss at the reset vector.
    applyStimulus(1'b0, 1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("cold_stall", {31'b0, inst_stall}, 32'd1);
    checkOutput("cold_hold_rdata", inst_sram_rdata, 32'h0);
    doRefill(32'hbfc00000, 32'hbfc00000, -1);
    checkOutput("cold_rdata", inst_sram_rdata, 32'hbfc00000);

    // Back-to-back hits.
    applyStimulus(1'b0, 1'b1, 32'hbfc00004, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit1_rdata", inst_sram_rdata, 32'hbfc00004);
    checkOutput("hit1_req", {31'b0, mem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hbfc00008, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit2_rdata", inst_sram_rdata, 32'hbfc00008);
    checkOutput("hit2_req", {31'b0, mem_req}, 32'd0);

    // Conflict miss on index 0 with a different tag.
    applyStimulus(1'b0, 1'b1, 32'hbfc00040, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("conf_stall", {31'b0, inst_stall}, 32'd1);
    checkOutput("conf_hold_rdata", inst_sram_rdata, 32'hbfc00008);
    doRefill(32'hbfc00040, 32'hbfc00040, -1);
    checkOutput("conf_rdata", inst_sram_rdata, 32'hbfc00040);

    // The evicted line misses again.
    applyStimulus(1'b0, 1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("evict_stall", {31'b0, inst_stall}, 32'd1);
    doRefill(32'hbfc00000, 32'hbfc00000, -1);
    checkOutput("evict_rdata", inst_sram_rdata, 32'hbfc00000);

    // A misaligned fetch returns zero and starts no refill.
    applyStimulus(1'b0, 1'b1, 32'hbfc00002, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mis_rdata", inst_sram_rdata, 32'h0);
    checkOutput("mis_req", {31'b0, mem_req}, 32'd0);
    checkOutput("mis_stall", {31'b0, inst_stall}, 32'd0);

    // An invalidate coinciding with a lookup of a resident line forces a miss.
    applyStimulus(1'b0, 1'b1, 32'hbfc00000, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("invlook_stall", {31'b0, inst_stall}, 32'd1);
    // An invalidate during the refill still returns the word.
    doRefill(32'hbfc00000, 32'hbfc00000, 1);
    checkOutput("invfill_rdata", inst_sram_rdata, 32'hbfc00000);
    // The line is left invalid, so a refetch misses.
    applyStimulus(1'b0, 1'b1, 32'hbfc00000, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("invrefetch_stall", {31'b0, inst_stall}, 32'd1);
    doRefill(32'hbfc00000, 32'hbfc00000, -1);
    applyStimulus(1'b0, 1'b1, 32'hbfc0000c, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("refill_hit_rdata", inst_sram_rdata, 32'hbfc0000c);
    checkOutput("refill_hit_stall", {31'b0, inst_stall}, 32'd0);

    // Reset after two acks of a refill.
    applyStimulus(1'b0, 1'b1, 32'hbfc00040, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 32'hbfc00040, 1'b0, 1'b1, 32'hbfc00040 + 32'(4 * k));
      tick();
    end
    checkOutput("midrst_maddr_pre", mem_addr, 32'hbfc00048);
    applyStimulus(1'b1, 1'b0, 32'hbfc00040, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("midrst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("midrst_stall", {31'b0, inst_stall}, 32'd0);
    checkOutput("midrst_maddr", mem_addr, 32'h0);
    checkOutput("midrst_rdata", inst_sram_rdata, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hbfc00040, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("postrst_stall", {31'b0, inst_stall}, 32'd1);
    doRefill(32'hbfc00040, 32'hbfc00040, -1);
    checkOutput("postrst_rdata", inst_sram_rdata, 32'hbfc00040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
